// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the 96x64 OLED display blocks: scene encoding,
// panel geometry, common RGB565 colours and a border-test helper.
// -----------------------------------------------------------------------------
package oled_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } scene_t;

    localparam int OLED_W      = 96;
    localparam int OLED_H      = 64;
    localparam int OLED_PIXELS = OLED_W * OLED_H;

    // Width of the pause overlay frame, in pixels.
    localparam int BORDER_W = 2;

    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] MAGENTA = 16'hF81F;

    // True when (x, y) lies within BORDER_W pixels of any panel edge.
    function automatic logic in_border(input logic [6:0] x, input logic [5:0] y);
        return (x < 7'(BORDER_W)) || (x >= 7'(OLED_W - BORDER_W)) ||
               (y < 6'(BORDER_W)) || (y >= 6'(OLED_H - BORDER_W));
    endfunction

endpackage

// File: rtl/oled_pixel_coord.sv
// -----------------------------------------------------------------------------
// oled_pixel_coord
// Converts the OLED driver's row-major raster index into registered column
// and row coordinates. Indices beyond the panel clamp to (0,0) and drop the
// valid flag so downstream colour logic can blank them.
//
// Ports:
//   clk            in   pixel clock
//   rst_n          in   async active-low reset
//   i_pixel_index  in   raster index, 0..OLED_PIXELS-1 nominal
//   o_x            out  column 0..95, registered
//   o_y            out  row 0..63, registered
//   o_valid        out  registered index-in-range flag
// -----------------------------------------------------------------------------
module oled_pixel_coord
    import oled_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] i_pixel_index,
    output logic [6:0]  o_x,
    output logic [5:0]  o_y,
    output logic        o_valid
);

    logic       w_in_range;
    logic [6:0] w_x;
    logic [5:0] w_y;

    assign w_in_range = (i_pixel_index < 13'(OLED_PIXELS));
    assign w_x        = 7'(i_pixel_index % 13'(OLED_W));
    assign w_y        = 6'(i_pixel_index / 13'(OLED_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_x     <= '0;
            o_y     <= '0;
            o_valid <= 1'b0;
        end else if (w_in_range) begin
            o_x     <= w_x;
            o_y     <= w_y;
            o_valid <= 1'b1;
        end else begin
            o_x     <= '0;
            o_y     <= '0;
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/oled_scene_sequencer.sv
// -----------------------------------------------------------------------------
// oled_scene_sequencer
// Scene controller for the 96x64 OLED game display. Runs the game-state
// machine, produces registered x/y for the renderers, selects the renderer
// colour for the driver and generates the flash enable used by PAUSE/OVER.
// Scene changes are committed only on frame_begin so a frame never mixes
// two scenes.
//
// Ports:
//   clk, rst_n                      pixel clock, async active-low reset
//   pixel_index                     raster index from the driver
//   frame_begin                     one-cycle start-of-frame pulse
//   btn_start, btn_pause            debounced single-cycle button pulses
//   game_over                       level from the game logic
//   title_data/play_data/over_data  renderer colours, driven from x/y
//   x, y                            registered coordinates (1-cycle latency)
//   scene_sel                       committed scene
//   active                          flash phase for the renderers
//   oled_data                       registered colour (2-cycle latency)
//
// Scene FSM (evaluated on the requested scene, committed at frame_begin):
//   state | meaning
//   TITLE | title screen, start -> PLAY
//   PLAY  | game running, game_over -> OVER, else pause -> PAUSE
//   PAUSE | frozen play view with flashing border, pause/start -> PLAY
//   OVER  | game-over screen, start -> TITLE
// -----------------------------------------------------------------------------
module oled_scene_sequencer
    import oled_pkg::*;
#(
    parameter int          FLASH_FRAMES  = 30,
    parameter logic [15:0] BORDER_COLOUR = 16'hFFE0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] pixel_index,
    input  logic        frame_begin,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        game_over,
    input  logic [15:0] title_data,
    input  logic [15:0] play_data,
    input  logic [15:0] over_data,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic [1:0]  scene_sel,
    output logic        active,
    output logic [15:0] oled_data
);

    localparam int CW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    scene_t        r_next_scene;
    scene_t        w_next_scene_d;
    scene_t        r_scene;
    logic [CW-1:0] r_flash_cnt;
    logic          r_active;
    logic [15:0]   r_oled;
    logic [15:0]   w_pixel;
    logic          w_valid;
    logic          w_scene_change;
    logic          w_flash_scene;

    oled_pixel_coord u_coord (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pixel_index (pixel_index),
        .o_x           (x),
        .o_y           (y),
        .o_valid       (w_valid)
    );

    // Requests chain on the pending scene, so only the last target in a
    // frame ever reaches scene_sel.
    always_comb begin
        w_next_scene_d = r_next_scene;
        case (r_next_scene)
            TITLE: if (btn_start) w_next_scene_d = PLAY;
            PLAY: begin
                if (game_over)      w_next_scene_d = OVER;
                else if (btn_pause) w_next_scene_d = PAUSE;
            end
            PAUSE: if (btn_pause || btn_start) w_next_scene_d = PLAY;
            OVER:  if (btn_start) w_next_scene_d = TITLE;
            default: w_next_scene_d = TITLE;
        endcase
    end

    // Commit samples the pending scene before this cycle's request lands,
    // so a request coinciding with frame_begin waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_scene <= TITLE;
            r_scene      <= TITLE;
        end else begin
            r_next_scene <= w_next_scene_d;
            if (frame_begin) r_scene <= r_next_scene;
        end
    end

    assign w_scene_change = frame_begin && (r_next_scene != r_scene);
    assign w_flash_scene  = (r_scene == PAUSE) || (r_scene == OVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash_cnt <= '0;
            r_active    <= 1'b0;
        end else if (w_scene_change || !w_flash_scene) begin
            r_flash_cnt <= '0;
            r_active    <= 1'b0;
        end else if (frame_begin) begin
            if (r_flash_cnt == CW'(FLASH_FRAMES - 1)) begin
                r_flash_cnt <= '0;
                r_active    <= ~r_active;
            end else begin
                r_flash_cnt <= r_flash_cnt + 1'b1;
            end
        end
    end

    // Uses the coordinate stage's x/y and the committed scene, so the first
    // pixel of a frame already reflects the scene committed on frame_begin.
    always_comb begin
        w_pixel = BLACK;
        if (w_valid) begin
            case (r_scene)
                TITLE: w_pixel = title_data;
                PLAY:  w_pixel = play_data;
                OVER:  w_pixel = over_data;
                PAUSE: w_pixel = (r_active && in_border(x, y)) ? BORDER_COLOUR : play_data;
                default: w_pixel = BLACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_oled <= BLACK;
        else        r_oled <= w_pixel;
    end

    assign scene_sel = r_scene;
    assign active    = r_active;
    assign oled_data = r_oled;

endmodule

// File: tb/tb_oled_scene_sequencer.sv
// -----------------------------------------------------------------------------
// tb_oled_scene_sequencer
// Scoreboard bench: each driven pixel index pushes its expected coordinates;
// one cycle later the entry is popped and compared against x/y, and it then
// forms the expected colour for the following cycle's oled_data together with
// a reference model of the scene/flash behaviour.
// -----------------------------------------------------------------------------
module tb_oled_scene_sequencer;

    localparam int          FF = 2;
    localparam logic [15:0] BC = 16'hFFE0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] pixel_index;
    logic        frame_begin, btn_start, btn_pause, game_over;
    logic [15:0] title_data, play_data, over_data;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [1:0]  scene_sel;
    logic        active;
    logic [15:0] oled_data;

    always #5 clk = ~clk;

    function automatic logic [15:0] rend(input logic [2:0] tag, input logic [6:0] cx,
                                         input logic [5:0] cy);
        return {tag, cy, cx};
    endfunction

    assign title_data = rend(3'b001, x, y);
    assign play_data  = rend(3'b010, x, y);
    assign over_data  = rend(3'b100, x, y);

    oled_scene_sequencer #(.FLASH_FRAMES(FF), .BORDER_COLOUR(BC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_index (pixel_index),
        .frame_begin (frame_begin),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .game_over   (game_over),
        .title_data  (title_data),
        .play_data   (play_data),
        .over_data   (over_data),
        .x           (x),
        .y           (y),
        .scene_sel   (scene_sel),
        .active      (active),
        .oled_data   (oled_data)
    );

    typedef struct {
        logic [6:0] x;
        logic [5:0] y;
        logic       v;
    } coord_t;

    coord_t q[$];
    coord_t st;
    int     m_next, m_scene, m_cnt;
    logic   m_active;
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic coord_t exp_coord(input int idx);
        coord_t c;
        if (idx < 6144) begin
            c.x = 7'(idx % 96);
            c.y = 6'(idx / 96);
            c.v = 1'b1;
        end else begin
            c.x = '0;
            c.y = '0;
            c.v = 1'b0;
        end
        return c;
    endfunction

    function automatic logic [15:0] exp_colour(input coord_t c, input int sc, input logic act);
        if (!c.v) return 16'h0000;
        case (sc)
            0: return rend(3'b001, c.x, c.y);
            1: return rend(3'b010, c.x, c.y);
            3: return rend(3'b100, c.x, c.y);
            default: begin
                if (act && (c.x < 2 || c.x > 93 || c.y < 2 || c.y > 61)) return BC;
                return rend(3'b010, c.x, c.y);
            end
        endcase
    endfunction

    task automatic model_reset();
        m_next   = 0;
        m_scene  = 0;
        m_cnt    = 0;
        m_active = 1'b0;
        st.x = '0;
        st.y = '0;
        st.v = 1'b0;
        q.delete();
    endtask

    task automatic step(input int idx, input bit fb, input bit s, input bit p);
        logic [15:0] ec;
        int          nn;
        pixel_index = 13'(idx);
        frame_begin = fb;
        btn_start   = s;
        btn_pause   = p;
        q.push_back(exp_coord(idx));
        @(posedge clk);
        ec = exp_colour(st, m_scene, m_active);
        nn = m_next;
        case (m_next)
            0: if (s) nn = 1;
            1: if (game_over) nn = 3; else if (p) nn = 2;
            2: if (p || s) nn = 1;
            3: if (s) nn = 0;
            default: nn = 0;
        endcase
        if (fb) begin
            if (m_next != m_scene) begin
                m_cnt    = 0;
                m_active = 1'b0;
            end else if (m_scene >= 2) begin
                if (m_cnt == FF - 1) begin
                    m_cnt    = 0;
                    m_active = ~m_active;
                end else begin
                    m_cnt++;
                end
            end
            m_scene = m_next;
        end
        m_next = nn;
        st = q.pop_front();
        #1;
        chk("x", 32'(x), 32'(st.x));
        chk("y", 32'(y), 32'(st.y));
        chk("scene_sel", 32'(scene_sel), 32'(m_scene));
        chk("active", 32'(active), 32'(m_active));
        chk("oled_data", 32'(oled_data), 32'(ec));
        frame_begin = 1'b0;
        btn_start   = 1'b0;
        btn_pause   = 1'b0;
    endtask

    // Short frame: 192 pixels on columns 0/32/64 of every row; g>=0 raises
    // game_over from pixel g to the end of the frame.
    task automatic frame(input int e1, input bit s1, input bit p1,
                         input int e2, input bit s2, input bit p2, input int g);
        for (int i = 0; i < 192; i++) begin
            if (g >= 0) game_over = (i >= g);
            step(i * 32, i == 0, (i == e1 && s1) || (i == e2 && s2),
                 (i == e1 && p1) || (i == e2 && p2));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_scene"}, 32'(scene_sel), 0);
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_oled"}, 32'(oled_data), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        pixel_index = '0;
        frame_begin = 1'b0;
        btn_start   = 1'b0;
        btn_pause   = 1'b0;
        game_over   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Full raster sweep in TITLE, then an out-of-range index.
        for (int i = 0; i < 6144; i++) step(i, i == 0, 1'b0, 1'b0);
        step(6200, 1'b0, 1'b0, 1'b0);
        step(97, 1'b0, 1'b0, 1'b0);
        step(6143, 1'b0, 1'b0, 1'b0);

        // Mid-frame start commits at the next frame boundary.
        frame(50, 1, 0, -1, 0, 0, -1);
        frame(-1, 0, 0, -1, 0, 0, -1);

        // game_over beats a simultaneous pause.
        frame(40, 0, 1, -1, 0, 0, 40);
        game_over = 1'b0;
        frame(-1, 0, 0, -1, 0, 0, -1);
        chk("over_commit", 32'(scene_sel), 3);

        // Start coinciding with frame_begin waits one more frame.
        frame(0, 1, 0, -1, 0, 0, -1);
        chk("over_hold", 32'(scene_sel), 3);
        frame(-1, 0, 0, -1, 0, 0, -1);
        chk("title_back", 32'(scene_sel), 0);

        // Back to PLAY, then pause+unpause inside one frame.
        frame(10, 1, 0, -1, 0, 0, -1);
        frame(20, 0, 1, 60, 0, 1, -1);
        frame(-1, 0, 0, -1, 0, 0, -1);
        chk("chain_stays_play", 32'(scene_sel), 1);

        // Pause flash; game_over is ignored while paused.
        frame(30, 0, 1, -1, 0, 0, -1);
        frame(-1, 0, 0, -1, 0, 0, -1);
        frame(-1, 0, 0, -1, 0, 0, 0);
        game_over = 1'b0;
        frame(-1, 0, 0, -1, 0, 0, -1);
        for (int i = 0; i < 50; i++) step(i * 32, i == 0, 1'b0, 1'b0);
        chk("pre_reset_active", 32'(active), 1);

        // Asynchronous reset mid-frame, checked between clock edges.
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("async");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame(-1, 0, 0, -1, 0, 0, -1);
        frame(-1, 0, 0, -1, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oled_scene_sequencer.md
# oled_scene_sequencer

Top-level scene controller for the 96x64 OLED game display. Runs the game-state machine (title, play, pause, game-over) and converts the OLED driver's raster `pixel_index` into registered `x`/`y` for the scene renderers. Selects which renderer's colour reaches the driver and generates the `active` flash enable. Scene changes are committed only at frame boundaries, so a frame never mixes two scenes. It sits between the OLED driver and the per-scene renderers (title, play, game-over).

## Interface
- `FLASH_FRAMES`, default 30: frames per half-period of the `active` flash.
- `BORDER_COLOUR`, default 16'hFFE0: pause-border overlay colour.

- `clk` in 1: OLED pixel clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `pixel_index` in 13: raster index from the OLED driver, 0..6143, row-major.
- `frame_begin` in 1: one-cycle pulse from the driver at the start of each frame.
- `btn_start` in 1: debounced single-cycle pulse.
- `btn_pause` in 1: debounced single-cycle pulse.
- `game_over` in 1: level from the game logic.
- `title_data`, `play_data`, `over_data` in 16 each: combinational RGB565 from the renderers, driven from `x`/`y`.
- `x` out 7: column, 0..95, registered.
- `y` out 6: row, 0..63, registered.
- `scene_sel` out 2: committed scene (TITLE=0, PLAY=1, PAUSE=2, OVER=3).
- `active` out 1: flash phase, passed to the renderers.
- `oled_data` out 16: registered pixel colour to the driver.

## Operation
- **Two state registers.**
  - `next_scene` updates immediately on requests.
  - `scene_sel` loads `next_scene` on the cycle `frame_begin`=1.
  - Transitions are evaluated against `next_scene`, so several requests in one frame chain, and only the last target is displayed.
- **Transitions** (evaluated each cycle):
  - TITLE: `btn_start` -> PLAY.
  - PLAY: `game_over` -> OVER; else `btn_pause` -> PAUSE. `game_over` wins over a simultaneous `btn_pause`.
  - PAUSE: `btn_pause` or `btn_start` -> PLAY. `game_over` is ignored while paused.
  - OVER: `btn_start` -> TITLE.
  - All other inputs hold the state.
- **Coordinates.**
  - `x` = `pixel_index` mod 96, `y` = `pixel_index` / 96, both registered.
  - For `pixel_index` ≥ 6144: `x`=0, `y`=0, and the matching `oled_data` is 16'h0000.
- **Colour mux** (registered, uses the committed `scene_sel`):
  - TITLE -> `title_data`.
  - PLAY -> `play_data`.
  - OVER -> `over_data`.
  - PAUSE -> `play_data`. When `active`=1 and the pixel lies in the 2-pixel border (x∈{0,1,94,95} or y∈{0,1,62,63}), output `BORDER_COLOUR` instead.
- **Flash.**
  - A frame counter (width clog2(`FLASH_FRAMES`)) runs only while `scene_sel` ∈ {PAUSE, OVER}.
  - It increments on `frame_begin`. On reaching `FLASH_FRAMES`-1 it wraps to 0 and `active` toggles.
  - On any change of `scene_sel`, the counter and `active` clear to 0.
  - In TITLE and PLAY, `active`=0.

## Timing
- **Reset values:** `scene_sel`=`next_scene`=TITLE, `x`=0, `y`=0, `oled_data`=16'h0000, `active`=0, flash counter 0.
- **Reset mid-frame:** all state is cleared asynchronously. Outputs stay at reset values until the first clock after `rst_n` deasserts.
- **Latency:**
  - `pixel_index` -> `x`/`y`: 1 cycle.
  - `pixel_index` -> `oled_data`: 2 cycles. The driver's index pipeline accounts for this.
- **Scene commit:** a request in cycle t is visible on `scene_sel` in the cycle after the next `frame_begin`.
  - A request in the same cycle as `frame_begin` is not committed by that pulse; it waits for the following frame.
- **Flash toggle:** `active` changes in the cycle after the `frame_begin` that wraps the counter.
- **Colour/scene alignment:** `oled_data` for the first pixel of a frame already uses the new `scene_sel`.

## Structure
- **Shared package `oled_pkg`:**
  - `scene_t` enum (TITLE, PLAY, PAUSE, OVER).
  - `OLED_W`=96, `OLED_H`=64, `OLED_PIXELS`=6144.
  - RGB565 colour constants (BLACK, WHITE, YELLOW, ...).
- **Sub-module `oled_pixel_coord`:** `pixel_index` -> registered `x`/`y` with out-of-range clamp. It is reusable by other display blocks.
- The FSM, flash counter and colour mux stay in `oled_scene_sequencer`.

## Test plan
- **Reset and coordinates:** reset, sweep `pixel_index` 0..6143.
  - `scene_sel`=0 and `oled_data` tracks `title_data` with 2-cycle lag.
  - Index 97 -> `x`=1, `y`=1; index 6143 -> `x`=95, `y`=63; index 6200 -> `oled_data`=0.
- **Frame-boundary commit:** `btn_start` at mid-frame in TITLE.
  - `scene_sel` stays 0 until the cycle after the next `frame_begin`, then becomes 1.
  - Frame N shows only title colours; frame N+1 shows only play colours.
- **Priority and chaining:**
  - In PLAY, pulse `btn_pause` and raise `game_over` in the same cycle -> `scene_sel`=3 at the next frame.
  - Pause then unpause within one frame -> `scene_sel` stays 1.
- **Pause flash:** enter PAUSE with `FLASH_FRAMES`=2.
  - `active` reads 0,0,1,1,0… per frame.
  - Border pixel (0,10) = 16'hFFE0 when `active`=1, otherwise `play_data`.
  - Interior pixels always equal `play_data`.
- **Game over flow:** in OVER, `btn_start` -> TITLE at the next frame, and `active` clears to 0 on the commit cycle.
- **Async reset mid-operation:** drop `rst_n` mid-frame while in PAUSE with `active`=1.
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - Normal TITLE output resumes after release.
